pipelined_logic_cmp_unit: RTL

Parametrised successor to the fixed 32-bit E/F logic comparator. It splits a 4-operand input word into lanes a/b/c/d of width W and computes E and F using one of four selectable logic modes. E and F travel in a length-aligned pipeline with valid/ready flow control, and each result is compared. The block reports per-beat match status and difference, and maintains saturating match and transaction counters. It sits between a stimulus source (counter or DMA) and a status/monitor register block.

---
 rtl/plc_pkg.sv | 14 +
 rtl/plc_sat_counter.sv | 23 ++
 rtl/pipelined_logic_cmp_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/plc_pkg.sv
// Shared types for the pipelined E/F logic comparator.
// Mode encoding matches the legacy fixed comparator for mode 0.
package plc_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_LEGACY = 2'd0,
        MODE_AND    = 2'd1,
        MODE_XOR    = 2'd2,
        MODE_ORD    = 2'd3
    } mode_t;

endpackage

// File: rtl/plc_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Clear wins over a same-cycle increment.
module plc_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipelined_logic_cmp_unit.sv
// Four-stage E/F logic comparator with global-stall valid/ready flow control
// and saturating match/transaction counters.
module pipelined_logic_cmp_unit
    import plc_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*W-1:0]    in_data,
    input  logic [MODE_W-1:0] in_mode,
    input  logic              clr_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_e,
    output logic [W-1:0]      out_f,
    output logic              out_match,
    output logic [W-1:0]      out_diff,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  txn_count
);

    typedef struct packed {
        logic           valid;
        mode_t          mode;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   c;
        logic [W-1:0]   d;
    } s1_t;

    typedef struct packed {
        logic           valid;
        mode_t          mode;
        logic [W-1:0]   a;
        logic [W-1:0]   bc_and;
        logic [W-1:0]   ad_or;
        logic [W-1:0]   ab_and;
        logic [W-1:0]   cd_and;
        logic [W-1:0]   ab_xor;
        logic [W-1:0]   cd_xor;
        logic [W-1:0]   bc_xnor;
    } s2_t;

    typedef struct packed {
        logic           valid;
        mode_t          mode;
        logic [W-1:0]   e;
        logic [W-1:0]   f;
    } s3_t;

    typedef struct packed {
        logic           valid;
        mode_t          mode;
        logic [W-1:0]   e;
        logic [W-1:0]   f;
        logic           match;
        logic [W-1:0]   diff;
    } s4_t;

    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    s3_t  s3_q, s3_d;
    s4_t  s4_q, s4_d;
    logic en;
    logic xfer;

    assign en       = !s4_q.valid || out_ready;
    assign in_ready = en;
    assign xfer     = s4_q.valid && out_ready;

    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.mode  = mode_t'(in_mode);
        s1_d.a     = in_data[W-1:0];
        s1_d.b     = in_data[2*W-1:W];
        s1_d.c     = in_data[3*W-1:2*W];
        s1_d.d     = in_data[4*W-1:3*W];

        // All candidate terms are formed here so S3 only has to select and combine.
        s2_d         = '0;
        s2_d.valid   = s1_q.valid;
        s2_d.mode    = s1_q.mode;
        s2_d.a       = s1_q.a;
        s2_d.bc_and  = s1_q.b & s1_q.c;
        s2_d.ad_or   = s1_q.a | s1_q.d;
        s2_d.ab_and  = s1_q.a & s1_q.b;
        s2_d.cd_and  = s1_q.c & s1_q.d;
        s2_d.ab_xor  = s1_q.a ^ s1_q.b;
        s2_d.cd_xor  = s1_q.c ^ s1_q.d;
        s2_d.bc_xnor = ~(s1_q.b ^ s1_q.c);

        s3_d       = '0;
        s3_d.valid = s2_q.valid;
        s3_d.mode  = s2_q.mode;
        case (s2_q.mode)
            MODE_LEGACY: begin
                s3_d.e = s2_q.a | s2_q.bc_and;
                s3_d.f = s2_q.bc_and ^ s2_q.ad_or;
            end
            MODE_AND: begin
                s3_d.e = s2_q.ab_and;
                s3_d.f = s2_q.cd_and;
            end
            MODE_XOR: begin
                s3_d.e = s2_q.ab_xor;
                s3_d.f = s2_q.cd_xor;
            end
            MODE_ORD: begin
                s3_d.e = s2_q.ad_or;
                s3_d.f = s2_q.bc_xnor;
            end
            default: ;
        endcase

        s4_d       = '0;
        s4_d.valid = s3_q.valid;
        s4_d.mode  = s3_q.mode;
        s4_d.e     = s3_q.e;
        s4_d.f     = s3_q.f;
        s4_d.match = (s3_q.e == s3_q.f);
        s4_d.diff  = s3_q.e ^ s3_q.f;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            s4_q <= '0;
        end else if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            s4_q <= s4_d;
        end
    end

    assign out_valid = s4_q.valid;
    assign out_e     = s4_q.e;
    assign out_f     = s4_q.f;
    assign out_match = s4_q.match;
    assign out_diff  = s4_q.diff;

    // Output-stage mode is carried only for debug visibility.
    logic unused_mode;
    assign unused_mode = ^s4_q.mode;

    plc_sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (xfer && s4_q.match),
        .clr   (clr_count),
        .count (match_count)
    );

    plc_sat_counter #(.CNT_W(CNT_W)) u_txn_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (xfer),
        .clr   (clr_count),
        .count (txn_count)
    );

endmodule
